// File: rtl/alu_mdu_pkg.sv
// Shared operation encodings for the execute-stage ALU and the multiply/divide unit.
// Both the top level and mdu_core decode these values.
package alu_mdu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MADD  = 4'd5;
  localparam logic [3:0] MD_MADDU = 4'd6;
  localparam logic [3:0] MD_MSUB  = 4'd7;
  localparam logic [3:0] MD_MSUBU = 4'd8;
  localparam logic [3:0] MD_MTHI  = 4'd9;
  localparam logic [3:0] MD_MTLO  = 4'd10;

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/alu_mdu_core.sv
// Multi-cycle multiply/divide unit: operand latches, IDLE/RUN cycle counter and HI/LO.
// The result is computed from the latched operands on the final edge of the countdown.
module mdu_core
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       md_op,
  input  logic             md_start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] opA_q, opA_d, opB_q, opB_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic             signedOp;
  logic [2*WIDTH-1:0] extA, extB, product, acc;
  logic             divZero;
  logic [WIDTH-1:0] divisor, quot, rem;

  // Arithmetic on the latched operands; sign extension to 2*WIDTH makes one multiplier serve both signednesses.
  always_comb begin
    signedOp = (op_q == MD_MULT) || (op_q == MD_DIV) || (op_q == MD_MADD) || (op_q == MD_MSUB);
    extA     = signedOp ? {{WIDTH{opA_q[WIDTH-1]}}, opA_q} : {{WIDTH{1'b0}}, opA_q};
    extB     = signedOp ? {{WIDTH{opB_q[WIDTH-1]}}, opB_q} : {{WIDTH{1'b0}}, opB_q};
    product  = extA * extB;
    acc      = {hi_q, lo_q};
    divZero  = (opB_q == '0);
    // MIN / -1 and x / 0 both divide by 1 instead: MIN/1 gives the required MIN rem 0.
    divisor  = (divZero || (signedOp && (opB_q == '1))) ? WIDTH'(1) : opB_q;
    if (signedOp && (opB_q == '1)) begin
      quot = opA_q;
      rem  = '0;
      if (opA_q != {1'b1, {(WIDTH-1){1'b0}}}) begin
        quot = -opA_q;
      end
    end else if (signedOp) begin
      quot = $signed(opA_q) / $signed(divisor);
      rem  = $signed(opA_q) % $signed(divisor);
    end else begin
      quot = opA_q / divisor;
      rem  = opA_q % divisor;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          if ((md_op >= MD_MULT) && (md_op <= MD_MSUBU)) begin
            opA_d   = a;
            opB_d   = b;
            op_d    = md_op;
            count_d = is_div(md_op) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            state_d = RUN;
          end else if (md_op == MD_MTHI) begin
            hi_d = a;
          end else if (md_op == MD_MTLO) begin
            lo_d = a;
          end
        end
      end
      default: begin
        if (count_q == CW'(1)) begin
          state_d = IDLE;
          count_d = '0;
          case (op_q)
            MD_MULT, MD_MULTU: {hi_d, lo_d} = product;
            MD_MADD, MD_MADDU: {hi_d, lo_d} = acc + product;
            MD_MSUB, MD_MSUBU: {hi_d, lo_d} = acc - product;
            MD_DIV, MD_DIVU: begin
              if (!divZero) begin
                hi_d = rem;
                lo_d = quot;
              end
            end
            default: ;
          endcase
        end else begin
          count_d = count_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      op_q    <= MD_NONE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage arithmetic: combinational 11-op ALU plus the multi-cycle MDU owning HI/LO.
// busy feeds the hazard unit so the pipeline stalls while an MDU operation runs.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       md_op,
  input  logic             md_start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] shamt;

  // Shift ops take the value from b and the amount from the low bits of a.
  always_comb begin
    shamt   = a[SW-1:0];
    alu_out = '0;
    case (alu_op)
      ALU_AND:  alu_out = a & b;
      ALU_OR:   alu_out = a | b;
      ALU_ADD:  alu_out = a + b;
      ALU_XOR:  alu_out = a ^ b;
      ALU_NOR:  alu_out = ~(a | b);
      ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SUB:  alu_out = a - b;
      ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  alu_out = b << shamt;
      ALU_SRL:  alu_out = b >> shamt;
      ALU_SRA:  alu_out = $signed(b) >>> shamt;
      default:  alu_out = '0;
    endcase
  end

  mdu_core #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .a        (a),
    .b        (b),
    .md_op    (md_op),
    .md_start (md_start),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

endmodule
